// File: rtl/tc2_ctrl.sv
// tc2_ctrl: round-robin sequencer in front of the L2 TLB cache. It serves up to NREQ miss
// ports through one L2 lookup port, launches page-table walks on miss, fills the L2 with
// walked entries and serialises invalidations against fills.
// Latency: hit -> req_ack 2 cycles after the request is sampled; miss -> req_ack 2 cycles
// after ptw_done (1 cycle on fault); invalidate -> inv_ack 1 cycle after inv_req is sampled.
// Backpressure: requesters and the invalidator hold their request until acked; one
// transaction is in flight at a time, and a pending invalidate waits for IDLE.
//
// Ports: clk/reset (sync, active-high); req_* requester side (flattened per-port slices);
// tc_* L2 lookup (registered address, combinational result); ptw_* walker handshake;
// wr_* L2 fill and invalidate strobes; inv_* invalidate request side.

module tc2_ctrl #(
    parameter  int VA_SZ = 64,
    parameter  int NPHYS = 56,
    parameter  int NREQ  = 3,
    localparam int IW    = $clog2(NREQ),
    localparam int VW    = VA_SZ - 12,
    localparam int PW    = NPHYS - 12
) (
    input  logic               clk,
    input  logic               reset,
    // requesters
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*VW-1:0] req_vaddr,
    input  logic [NREQ*16-1:0] req_asid,
    output logic [NREQ-1:0]    req_ack,
    output logic               rsp_fault,
    output logic [PW-1:0]      rsp_paddr,
    output logic [6:0]         rsp_gaduwrx,
    output logic [3:0]         rsp_pgsz,
    // L2 lookup
    output logic [VW-1:0]      tc_vaddr,
    output logic [15:0]        tc_asid,
    input  logic               tc_hit,
    input  logic [PW-1:0]      tc_paddr,
    input  logic [6:0]         tc_gaduwrx,
    input  logic [3:0]         tc_pgsz,
    // page-table walker
    output logic               ptw_req,
    output logic [VW-1:0]      ptw_vaddr,
    output logic [15:0]        ptw_asid,
    input  logic               ptw_done,
    input  logic               ptw_fault,
    input  logic [PW-1:0]      ptw_paddr,
    input  logic [6:0]         ptw_gaduwrx,
    input  logic [3:0]         ptw_pgsz,
    // L2 fill
    output logic               wr_entry,
    output logic [VW-1:0]      wr_vaddr,
    output logic [PW-1:0]      wr_paddr,
    output logic [15:0]        wr_asid,
    output logic [6:0]         wr_gaduwrx,
    output logic [3:0]         wr_pgsz,
    // invalidate
    input  logic               inv_req,
    input  logic               inv_addr_en,
    input  logic               inv_asid_en,
    input  logic               inv_unified,
    input  logic [VW-1:0]      inv_vaddr,
    input  logic [15:0]        inv_asid,
    output logic               inv_ack,
    output logic               wr_invalidate,
    output logic               wr_invalidate_addr,
    output logic               wr_invalidate_asid,
    output logic               wr_inv_unified,
    output logic [VW-1:0]      wr_inv_vaddr,
    output logic [15:0]        wr_inv_asid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INV,
        S_LOOKUP,
        S_WALK,
        S_FILL,
        S_RESP
    } state_t;

    state_t          state_q,  state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   id_q,     id_d;
    logic [VW-1:0]   vaddr_q,  vaddr_d;
    logic [15:0]     asid_q,   asid_d;
    logic [PW-1:0]   paddr_q,  paddr_d;
    logic [6:0]      gad_q,    gad_d;
    logic [3:0]      pgsz_q,   pgsz_d;
    logic            fault_q,  fault_d;

    // Round-robin pick: scan offsets from the far end down so the smallest offset from
    // rr_ptr (the first set bit at or after it, with wrap) is the last one written.
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand_sum;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_sum = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IW+1)'(NREQ);
            end
            if (req_valid[cand_sum[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand_sum[IW-1:0];
            end
        end
    end

    // Next-state and datapath latches
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        vaddr_d  = vaddr_q;
        asid_d   = asid_q;
        paddr_d  = paddr_q;
        gad_d    = gad_q;
        pgsz_d   = pgsz_q;
        fault_d  = fault_q;

        case (state_q)
            S_IDLE: begin
                if (inv_req) begin
                    state_d = S_INV;
                end else if (pick_vld) begin
                    id_d    = pick_idx;
                    vaddr_d = req_vaddr[int'(pick_idx)*VW +: VW];
                    asid_d  = req_asid[int'(pick_idx)*16 +: 16];
                    state_d = S_LOOKUP;
                end
            end
            S_INV: begin
                state_d = S_IDLE;
            end
            S_LOOKUP: begin
                if (tc_hit) begin
                    paddr_d = tc_paddr;
                    gad_d   = tc_gaduwrx;
                    pgsz_d  = tc_pgsz;
                    fault_d = 1'b0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (ptw_done) begin
                    paddr_d = ptw_paddr;
                    gad_d   = ptw_gaduwrx;
                    pgsz_d  = ptw_pgsz;
                    fault_d = ptw_fault;
                    // faulting walks are reported but never written into the L2
                    state_d = ptw_fault ? S_RESP : S_FILL;
                end
            end
            S_FILL: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                rr_ptr_d = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            vaddr_q  <= '0;
            asid_q   <= '0;
            paddr_q  <= '0;
            gad_q    <= '0;
            pgsz_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            vaddr_q  <= vaddr_d;
            asid_q   <= asid_d;
            paddr_q  <= paddr_d;
            gad_q    <= gad_d;
            pgsz_q   <= pgsz_d;
            fault_q  <= fault_d;
        end
    end

    // Strobes are decoded from state only, so fill (FILL) and invalidate (INV) are
    // mutually exclusive by construction.
    always_comb begin
        req_ack = '0;
        if (state_q == S_RESP) begin
            req_ack[id_q] = 1'b1;
        end
        ptw_req            = (state_q == S_WALK);
        wr_entry           = (state_q == S_FILL);
        inv_ack            = (state_q == S_INV);
        wr_invalidate      = (state_q == S_INV);
        wr_invalidate_addr = (state_q == S_INV) && inv_addr_en;
        wr_invalidate_asid = (state_q == S_INV) && inv_asid_en;
        wr_inv_unified     = (state_q == S_INV) && inv_unified;
        wr_inv_vaddr       = (state_q == S_INV) ? inv_vaddr : '0;
        wr_inv_asid        = (state_q == S_INV) ? inv_asid  : '0;
    end

    assign rsp_fault   = fault_q;
    assign rsp_paddr   = paddr_q;
    assign rsp_gaduwrx = gad_q;
    assign rsp_pgsz    = pgsz_q;

    assign tc_vaddr    = vaddr_q;
    assign tc_asid     = asid_q;
    assign ptw_vaddr   = vaddr_q;
    assign ptw_asid    = asid_q;

    assign wr_vaddr    = vaddr_q;
    assign wr_paddr    = paddr_q;
    assign wr_asid     = asid_q;
    assign wr_gaduwrx  = gad_q;
    assign wr_pgsz     = pgsz_q;

endmodule

// File: tb/tb_tc2_ctrl.sv
// tb_tc2_ctrl: scoreboard bench for tc2_ctrl. Expected responses are queued when a request
// (or walk completion) is driven and checked by a negedge monitor when req_ack fires.
// Event timing of fills, invalidates and walk requests is recorded by the same monitor.

module tb_tc2_ctrl;

    localparam int VA = 64;
    localparam int NP = 56;
    localparam int N  = 3;
    localparam int VW = VA - 12;
    localparam int PW = NP - 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*VW-1:0]   req_vaddr;
    logic [N*16-1:0]   req_asid;
    logic [N-1:0]      req_ack;
    logic              rsp_fault;
    logic [PW-1:0]     rsp_paddr;
    logic [6:0]        rsp_gaduwrx;
    logic [3:0]        rsp_pgsz;
    logic [VW-1:0]     tc_vaddr;
    logic [15:0]       tc_asid;
    logic              tc_hit;
    logic [PW-1:0]     tc_paddr;
    logic [PW-1:0]     tc_paddr_v;
    logic              tc_echo;
    logic [6:0]        tc_gaduwrx;
    logic [3:0]        tc_pgsz;
    logic              ptw_req;
    logic [VW-1:0]     ptw_vaddr;
    logic [15:0]       ptw_asid;
    logic              ptw_done;
    logic              ptw_fault;
    logic [PW-1:0]     ptw_paddr;
    logic [6:0]        ptw_gaduwrx;
    logic [3:0]        ptw_pgsz;
    logic              wr_entry;
    logic [VW-1:0]     wr_vaddr;
    logic [PW-1:0]     wr_paddr;
    logic [15:0]       wr_asid;
    logic [6:0]        wr_gaduwrx;
    logic [3:0]        wr_pgsz;
    logic              inv_req;
    logic              inv_addr_en;
    logic              inv_asid_en;
    logic              inv_unified;
    logic [VW-1:0]     inv_vaddr;
    logic [15:0]       inv_asid;
    logic              inv_ack;
    logic              wr_invalidate;
    logic              wr_invalidate_addr;
    logic              wr_invalidate_asid;
    logic              wr_inv_unified;
    logic [VW-1:0]     wr_inv_vaddr;
    logic [15:0]       wr_inv_asid;

    // L2 model: in echo mode the returned PA is the low bits of the looked-up VA, which
    // exposes which requester's address was latched.
    assign tc_paddr = tc_echo ? tc_vaddr[PW-1:0] : tc_paddr_v;

    tc2_ctrl #(.VA_SZ(VA), .NPHYS(NP), .NREQ(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_vaddr(req_vaddr), .req_asid(req_asid),
        .req_ack(req_ack), .rsp_fault(rsp_fault), .rsp_paddr(rsp_paddr),
        .rsp_gaduwrx(rsp_gaduwrx), .rsp_pgsz(rsp_pgsz),
        .tc_vaddr(tc_vaddr), .tc_asid(tc_asid), .tc_hit(tc_hit), .tc_paddr(tc_paddr),
        .tc_gaduwrx(tc_gaduwrx), .tc_pgsz(tc_pgsz),
        .ptw_req(ptw_req), .ptw_vaddr(ptw_vaddr), .ptw_asid(ptw_asid),
        .ptw_done(ptw_done), .ptw_fault(ptw_fault), .ptw_paddr(ptw_paddr),
        .ptw_gaduwrx(ptw_gaduwrx), .ptw_pgsz(ptw_pgsz),
        .wr_entry(wr_entry), .wr_vaddr(wr_vaddr), .wr_paddr(wr_paddr), .wr_asid(wr_asid),
        .wr_gaduwrx(wr_gaduwrx), .wr_pgsz(wr_pgsz),
        .inv_req(inv_req), .inv_addr_en(inv_addr_en), .inv_asid_en(inv_asid_en),
        .inv_unified(inv_unified), .inv_vaddr(inv_vaddr), .inv_asid(inv_asid),
        .inv_ack(inv_ack), .wr_invalidate(wr_invalidate),
        .wr_invalidate_addr(wr_invalidate_addr), .wr_invalidate_asid(wr_invalidate_asid),
        .wr_inv_unified(wr_inv_unified), .wr_inv_vaddr(wr_inv_vaddr),
        .wr_inv_asid(wr_inv_asid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        logic [N-1:0]  ack;
        logic          fault;
        logic [PW-1:0] paddr;
        logic [6:0]    gad;
        logic [3:0]    pgsz;
        int            at;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input logic [N-1:0] ack, input logic fault,
                            input logic [PW-1:0] paddr, input logic [6:0] gad,
                            input logic [3:0] pgsz, input int at);
        exp_t e;
        e.ack = ack; e.fault = fault; e.paddr = paddr; e.gad = gad; e.pgsz = pgsz; e.at = at;
        sb.push_back(e);
    endtask

    // monitor state
    int            n_acks = 0;
    int            n_wr   = 0;
    int            n_inv  = 0;
    int            n_ptw  = 0;
    int            wr_cyc = -1;
    int            inv_cyc = -1;
    int            inv_ack_cyc = -1;
    logic [VW-1:0] wr_va_s;
    logic [PW-1:0] wr_pa_s;
    logic [3:0]    wr_pg_s;
    logic [15:0]   wr_asid_s;
    logic [3:0]    inv_qual_s;
    logic [VW-1:0] inv_va_s;

    always @(negedge clk) begin
        if (!reset) begin
            if (req_ack != '0) begin
                n_acks++;
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 64'(req_ack), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_vec", 64'(req_ack), 64'(e.ack));
                    chk("ack_cycle", 64'(cyc), 64'(e.at));
                    chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                    if (!e.fault) begin
                        chk("rsp_paddr", 64'(rsp_paddr), 64'(e.paddr));
                        chk("rsp_gaduwrx", 64'(rsp_gaduwrx), 64'(e.gad));
                        chk("rsp_pgsz", 64'(rsp_pgsz), 64'(e.pgsz));
                    end
                end
            end
            if (wr_entry) begin
                n_wr++;
                wr_cyc    = cyc;
                wr_va_s   = wr_vaddr;
                wr_pa_s   = wr_paddr;
                wr_pg_s   = wr_pgsz;
                wr_asid_s = wr_asid;
            end
            if (wr_invalidate) begin
                n_inv++;
                inv_cyc    = cyc;
                inv_qual_s = {wr_invalidate, wr_invalidate_addr, wr_invalidate_asid,
                              wr_inv_unified};
                inv_va_s   = wr_inv_vaddr;
            end
            if (inv_ack) inv_ack_cyc = cyc;
            if (wr_entry || wr_invalidate) begin
                chk("fill_inv_exclusive", 64'(wr_entry & wr_invalidate), 64'd0);
            end
            if (ptw_req) n_ptw++;
        end
    end

    task automatic set_req(input int i, input logic [VW-1:0] va, input logic [15:0] asid);
        req_vaddr[i*VW +: VW] = va;
        req_asid[i*16 +: 16]  = asid;
    endtask

    task automatic wait_acks(input int target);
        for (int i = 0; i < 40; i++) begin
            if (n_acks >= target) break;
            @(negedge clk);
            #1;
        end
        chk("ack_wait", 64'(n_acks >= target), 64'd1);
    endtask

    task automatic wait_inv(input int target);
        for (int i = 0; i < 40; i++) begin
            if (n_inv >= target) break;
            @(negedge clk);
            #1;
        end
        chk("inv_wait", 64'(n_inv >= target), 64'd1);
    endtask

    task automatic wait_ptw(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (ptw_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ptw_wait", 64'(seen), 64'd1);
    endtask

    task automatic pulse_done(input logic fault, input logic [PW-1:0] pa,
                              input logic [6:0] gad, input logic [3:0] pg);
        ptw_done = 1'b1; ptw_fault = fault; ptw_paddr = pa; ptw_gaduwrx = gad; ptw_pgsz = pg;
        @(posedge clk);
        #1;
        ptw_done = 1'b0; ptw_fault = 1'b0;
    endtask

    initial begin
        int  c, k, t, w0, p0, a0;
        bit  seen;
        reset = 1'b1;
        req_valid = '0; req_vaddr = '0; req_asid = '0;
        tc_hit = 1'b0; tc_paddr_v = '0; tc_echo = 1'b0; tc_gaduwrx = '0; tc_pgsz = '0;
        ptw_done = 1'b0; ptw_fault = 1'b0; ptw_paddr = '0; ptw_gaduwrx = '0; ptw_pgsz = '0;
        inv_req = 1'b0; inv_addr_en = 1'b0; inv_asid_en = 1'b0; inv_unified = 1'b0;
        inv_vaddr = '0; inv_asid = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        chk("rst_req_ack", 64'(req_ack), 64'd0);
        chk("rst_ptw_req", 64'(ptw_req), 64'd0);
        chk("rst_wr_entry", 64'(wr_entry), 64'd0);
        chk("rst_inv", 64'({inv_ack, wr_invalidate, wr_invalidate_addr, wr_invalidate_asid,
                            wr_inv_unified}), 64'd0);
        chk("rst_tc_vaddr", 64'(tc_vaddr), 64'd0);
        chk("rst_rsp_paddr", 64'(rsp_paddr), 64'd0);

        // hit on requester 1
        set_req(1, 52'h12345, 16'h0011);
        tc_hit = 1'b1; tc_paddr_v = 44'hABC; tc_gaduwrx = 7'h5B; tc_pgsz = 4'b0000;
        p0 = n_ptw;
        @(posedge clk);
        #1;
        c = cyc;
        req_valid = 3'b010;
        push_exp(3'b010, 1'b0, 44'hABC, 7'h5B, 4'b0000, c + 2);
        @(posedge clk);
        #1;
        chk("hit_tc_vaddr", 64'(tc_vaddr), 64'h12345);
        chk("hit_tc_asid", 64'(tc_asid), 64'h0011);
        wait_acks(1);
        req_valid = '0;
        chk("hit_no_ptw", 64'(n_ptw - p0), 64'd0);

        // miss on requester 0, walk completes 5 cycles after ptw_req rises
        set_req(0, 52'h0ABCDE, 16'h0022);
        tc_hit = 1'b0;
        w0 = n_wr;
        @(posedge clk);
        #1;
        c = cyc;
        req_valid = 3'b001;
        wait_ptw(seen);
        chk("miss_ptw_rise", 64'(cyc), 64'(c + 2));
        chk("miss_ptw_vaddr", 64'(ptw_vaddr), 64'h0ABCDE);
        chk("miss_ptw_asid", 64'(ptw_asid), 64'h0022);
        repeat (5) @(posedge clk);
        #1;
        k = cyc;
        push_exp(3'b001, 1'b0, 44'h777, 7'h4F, 4'b0001, k + 2);
        pulse_done(1'b0, 44'h777, 7'h4F, 4'b0001);
        wait_acks(2);
        req_valid = '0;
        chk("miss_wr_count", 64'(n_wr - w0), 64'd1);
        chk("miss_wr_cycle", 64'(wr_cyc), 64'(k + 1));
        chk("miss_wr_vaddr", 64'(wr_va_s), 64'h0ABCDE);
        chk("miss_wr_paddr", 64'(wr_pa_s), 64'h777);
        chk("miss_wr_pgsz", 64'(wr_pg_s), 64'b0001);
        chk("miss_wr_asid", 64'(wr_asid_s), 64'h0022);

        // walk fault on requester 2: no fill, ack the cycle after ptw_done
        set_req(2, 52'h0F00D, 16'h0033);
        w0 = n_wr;
        @(posedge clk);
        #1;
        req_valid = 3'b100;
        wait_ptw(seen);
        repeat (2) @(posedge clk);
        #1;
        k = cyc;
        push_exp(3'b100, 1'b1, '0, '0, '0, k + 1);
        pulse_done(1'b1, 44'h999, 7'h7F, 4'b0010);
        wait_acks(3);
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("fault_no_fill", 64'(n_wr - w0), 64'd0);

        // round robin with all requesters held, every lookup hits
        set_req(0, 52'h100, 16'h0A00);
        set_req(1, 52'h200, 16'h0B00);
        set_req(2, 52'h300, 16'h0C00);
        tc_hit = 1'b1; tc_echo = 1'b1; tc_gaduwrx = 7'h11; tc_pgsz = 4'b0100;
        @(posedge clk);
        #1;
        c = cyc;
        req_valid = 3'b111;
        push_exp(3'b001, 1'b0, 44'h100, 7'h11, 4'b0100, c + 2);
        push_exp(3'b010, 1'b0, 44'h200, 7'h11, 4'b0100, c + 5);
        push_exp(3'b100, 1'b0, 44'h300, 7'h11, 4'b0100, c + 8);
        push_exp(3'b001, 1'b0, 44'h100, 7'h11, 4'b0100, c + 11);
        wait_acks(7);
        req_valid = '0;
        tc_echo = 1'b0;

        // invalidate raised during a walk: fill first, invalidate strictly after
        set_req(1, 52'h4242, 16'h0044);
        tc_hit = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 3'b010;
        wait_ptw(seen);
        inv_req = 1'b1; inv_addr_en = 1'b1; inv_asid_en = 1'b0; inv_unified = 1'b1;
        inv_vaddr = 52'h5555; inv_asid = 16'h0077;
        repeat (3) @(posedge clk);
        #1;
        k = cyc;
        push_exp(3'b010, 1'b0, 44'h888, 7'h22, 4'b0000, k + 2);
        pulse_done(1'b0, 44'h888, 7'h22, 4'b0000);
        wait_acks(8);
        req_valid = '0;
        wait_inv(1);
        inv_req = 1'b0;
        chk("inv_fill_cycle", 64'(wr_cyc), 64'(k + 1));
        chk("inv_cycle", 64'(inv_cyc), 64'(k + 4));
        chk("inv_after_fill", 64'(inv_cyc > wr_cyc), 64'd1);
        chk("inv_ack_aligned", 64'(inv_ack_cyc), 64'(inv_cyc));
        chk("inv_qualifiers", 64'(inv_qual_s), 64'b1101);
        chk("inv_vaddr", 64'(inv_va_s), 64'h5555);

        // inv_req and req_valid together in IDLE: invalidate served first
        set_req(0, 52'h6000, 16'h0055);
        tc_hit = 1'b1; tc_paddr_v = 44'h321; tc_gaduwrx = 7'h33; tc_pgsz = 4'b1000;
        @(posedge clk);
        #1;
        t = cyc;
        inv_req = 1'b1; inv_addr_en = 1'b0; inv_asid_en = 1'b1; inv_unified = 1'b0;
        req_valid = 3'b001;
        push_exp(3'b001, 1'b0, 44'h321, 7'h33, 4'b1000, t + 4);
        wait_inv(2);
        inv_req = 1'b0;
        chk("prio_inv_cycle", 64'(inv_cyc), 64'(t + 1));
        chk("prio_inv_qual", 64'(inv_qual_s), 64'b1010);
        wait_acks(9);
        req_valid = '0;

        // ptw_done outside WALK is ignored
        w0 = n_wr;
        a0 = n_acks;
        @(posedge clk);
        #1;
        pulse_done(1'b0, 44'hDEAD, 7'h01, 4'b0001);
        repeat (4) @(posedge clk);
        #1;
        chk("stray_done_fill", 64'(n_wr - w0), 64'd0);
        chk("stray_done_ack", 64'(n_acks - a0), 64'd0);

        // reset during a walk
        set_req(2, 52'h7777, 16'h0066);
        tc_hit = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 3'b100;
        wait_ptw(seen);
        reset = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rstwalk_ptw_req", 64'(ptw_req), 64'd0);
        chk("rstwalk_tc_vaddr", 64'(tc_vaddr), 64'd0);
        chk("rstwalk_req_ack", 64'(req_ack), 64'd0);
        // rr_ptr back at 0: requester 0 wins over 2 (it was 1 before reset, which picks 2)
        set_req(0, 52'h8080, 16'h0088);
        tc_hit = 1'b1; tc_paddr_v = 44'h99; tc_gaduwrx = 7'h44; tc_pgsz = 4'b0000;
        @(posedge clk);
        #1;
        c = cyc;
        req_valid = 3'b101;
        push_exp(3'b001, 1'b0, 44'h99, 7'h44, 4'b0000, c + 2);
        wait_acks(10);
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
